// File: rtl/bus_unpack_pkg.sv
// Shared constants for the word-bus reader: bus word width and the
// element-count-to-word-count helper width margin.
package bus_unpack_pkg;

   localparam int unsigned WordW      = 64;
   localparam int unsigned WordShift  = 6;
   // Extra product bits so numElems*W never overflows for W up to 64.
   localparam int unsigned MulMargin  = 7;

endpackage

// File: rtl/bus_unpack_counter.sv
// Down-counter with immediate load: o_count shows the loaded value in the
// same cycle, o_count_q is the registered value only.
module bus_unpack_counter #(
   parameter int unsigned Width = 14
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [Width-1:0] i_load_val,
   input  logic             i_dec,
   input  logic             i_clr,
   output logic [Width-1:0] o_count,
   output logic [Width-1:0] o_count_q
);

   logic [Width-1:0] r_count;
   logic [Width-1:0] w_count;

   assign w_count   = i_load ? i_load_val : r_count;
   assign o_count   = w_count;
   assign o_count_q = r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_count <= '0;
      end else begin
         r_count <= w_count - Width'(i_dec);
      end
   end

endmodule

// File: rtl/bus_unpack.sv
// Reader end of the 64-bit word bus: unpacks continuously packed W-bit
// elements, LSB-first, from a stream of 64-bit words.
module bus_unpack
   import bus_unpack_pkg::*;
#(
   parameter int unsigned W         = 15,
   parameter int unsigned MAX_ELEMS = 10752
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_cmd_start,
   input  logic [$clog2(MAX_ELEMS+1)-1:0]     i_cmd_num_elems,
   output logic                               o_cmd_can_receive,
   input  logic [63:0]                        i_in,
   input  logic                               i_in_is_ready,
   output logic                               o_in_can_receive,
   output logic                               o_in_is_last,
   output logic [W-1:0]                       o_out,
   output logic                               o_out_is_ready,
   input  logic                               i_out_can_receive,
   output logic                               o_out_is_last
);

   localparam int unsigned CW = $clog2(MAX_ELEMS + 1);
   localparam int unsigned MW = CW + MulMargin;
   localparam int unsigned BW = WordW + W - 1;
   localparam int unsigned FW = $clog2(BW + 1);

   logic [BW-1:0] r_buf;
   logic [FW-1:0] r_fill;

   logic          w_start;
   logic [MW-1:0] w_prod;
   logic [CW-1:0] w_words_calc;
   logic [CW-1:0] w_elems;
   logic [CW-1:0] w_elems_q;
   logic [CW-1:0] w_words;
   logic [CW-1:0] w_words_q;
   logic          w_out_rdy;
   logic          w_in_xfer;
   logic          w_done;
   logic [FW-1:0] w_post_fill;
   logic [FW-1:0] w_fill_d;
   logic [BW-1:0] w_post_buf;
   logic [BW-1:0] w_ins;
   logic [BW-1:0] w_buf_d;

   assign o_cmd_can_receive = (w_elems_q == '0) && (w_words_q == '0);
   assign w_start           = i_cmd_start && o_cmd_can_receive && !i_rst;

   assign w_prod       = MW'(i_cmd_num_elems) * MW'(W);
   assign w_words_calc = CW'((w_prod + MW'(WordW - 1)) >> WordShift);

   bus_unpack_counter #(
      .Width (CW)
   ) u_elems (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_start),
      .i_load_val (i_cmd_num_elems),
      .i_dec      (w_out_rdy),
      .i_clr      (w_done),
      .o_count    (w_elems),
      .o_count_q  (w_elems_q)
   );

   bus_unpack_counter #(
      .Width (CW)
   ) u_words (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_start),
      .i_load_val (w_words_calc),
      .i_dec      (w_in_xfer),
      .i_clr      (w_done),
      .o_count    (w_words),
      .o_count_q  (w_words_q)
   );

   assign w_out_rdy = !i_rst && (w_elems != '0) && (r_fill >= FW'(W)) && i_out_can_receive;

   // A word may land in the same cycle an element leaves, so the insert
   // position is the fill level after this cycle's shift.
   assign w_post_fill      = r_fill - (w_out_rdy ? FW'(W) : '0);
   assign o_in_can_receive = !i_rst && (w_words != '0) && (w_post_fill < FW'(W));
   assign w_in_xfer        = i_in_is_ready && o_in_can_receive;

   assign w_post_buf = w_out_rdy ? (r_buf >> W) : r_buf;
   assign w_ins      = BW'(i_in) << w_post_fill;
   assign w_buf_d    = w_post_buf | (w_in_xfer ? w_ins : '0);
   assign w_fill_d   = w_post_fill + (w_in_xfer ? FW'(WordW) : '0);

   // Last element leaving (or nothing pending): drop pad bits and any words left.
   assign w_done = (w_elems == '0) || (w_out_rdy && (w_elems == CW'(1)));

   always_ff @(posedge i_clk) begin
      if (i_rst || w_done) begin
         r_buf  <= '0;
         r_fill <= '0;
      end else begin
         r_buf  <= w_buf_d;
         r_fill <= w_fill_d;
      end
   end

   assign o_out          = r_buf[W-1:0];
   assign o_out_is_ready = w_out_rdy;
   assign o_in_is_last   = o_in_can_receive && (w_words == CW'(1));
   assign o_out_is_last  = w_out_rdy && (w_elems == CW'(1));

endmodule
